ofmap_packer: RTL and testbench

OFMAP_PACKER -- requirements
Module: ofmap_packer

---
 rtl/ofmap_packer.sv | 177 +++++++++++++++++
 tb/tb_ofmap_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_packer.sv
// ofmap_packer: packs reLU results (CONV element stream or MUL matrix rows) into
// WIDTH-lane output words queued in a FIFO, with a last-row marker per word.
module ofmap_packer #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 load_layer_info,
    input  logic                                 op_sel,
    input  logic [3:0]                           o_width,
    input  logic [3:0]                           o_height,
    input  logic [3:0]                           mul_b_w,
    input  logic [3:0]                           mul_b_h,
    input  logic                                 conv_iv,
    input  logic [DATA_WIDTH-1:0]                conv_id,
    input  logic                                 mul_iv,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   mul_id,
    output logic                                 out_ov,
    output logic [WIDTH*DATA_WIDTH-1:0]          out_od,
    output logic                                 out_last,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 overflow
);
    localparam int WW = WIDTH * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CONV_PACK, MUL_DRAIN} state_t;
    state_t r_state, w_next_state;

    logic                 r_op_sel;
    logic [3:0]           r_o_width, r_o_height, r_mul_b_w, r_mul_b_h;
    logic [3:0]           r_col_cnt, r_row_cnt, r_row_idx;
    logic [WW-1:0]        r_pack;
    logic [HEIGHT*WW-1:0] r_mul;
    logic                 r_overflow;
    logic [WW:0]          r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wptr, r_rptr;

    logic [4:0]    w_ow, w_oh, w_bw, w_bh;
    logic          w_empty, w_full, w_pop, w_push;
    logic          w_conv_accept, w_conv_eol, w_conv_last, w_drop;
    logic          w_mul_accept, w_mul_push, w_mul_last, w_ignore;
    logic [WW-1:0] w_conv_word, w_mul_word, w_push_word;
    logic          w_push_last;

    // A size field of 0 encodes the full 8
    assign w_ow = (r_o_width  == 4'd0) ? 5'd8 : {1'b0, r_o_width};
    assign w_oh = (r_o_height == 4'd0) ? 5'd8 : {1'b0, r_o_height};
    assign w_bw = (r_mul_b_w  == 4'd0) ? 5'd8 : {1'b0, r_mul_b_w};
    assign w_bh = (r_mul_b_h  == 4'd0) ? 5'd8 : {1'b0, r_mul_b_h};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;

    assign w_conv_accept = conv_iv && (r_state == CONV_PACK) && !load_layer_info;
    assign w_conv_eol    = w_conv_accept && ({1'b0, r_col_cnt} == w_ow - 5'd1);
    assign w_conv_last   = ({1'b0, r_row_cnt} == w_oh - 5'd1);
    assign w_drop        = w_conv_eol && w_full && !w_pop;

    assign w_mul_accept = mul_iv && (r_state == IDLE) && r_op_sel && !load_layer_info;
    assign w_mul_push   = (r_state == MUL_DRAIN) && !load_layer_info && (!w_full || w_pop);
    assign w_mul_last   = ({1'b0, r_row_idx} == w_bh - 5'd1);

    assign w_ignore = !load_layer_info &&
                      ((mul_iv && !w_mul_accept) || (conv_iv && (r_state != CONV_PACK)));

    assign w_push      = w_mul_push || (w_conv_eol && (!w_full || w_pop));
    assign w_push_word = w_mul_push ? w_mul_word : w_conv_word;
    assign w_push_last = w_mul_push ? w_mul_last : w_conv_last;

    // Unused lanes of r_pack stay zero because the register clears after every row
    always_comb begin
        w_conv_word = r_pack;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            if (c == 32'(r_col_cnt)) w_conv_word[c*DATA_WIDTH +: DATA_WIDTH] = conv_id;
        end
    end

    always_comb begin
        w_mul_word = '0;
        for (int unsigned r = 0; r < HEIGHT; r++) begin
            if (r == 32'(r_row_idx)) w_mul_word = r_mul[r*WW +: WW];
        end
        for (int unsigned c = 0; c < WIDTH; c++) begin
            if (c >= 32'(w_bw)) w_mul_word[c*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (load_layer_info) begin
            w_next_state = op_sel ? IDLE : CONV_PACK;
        end else begin
            case (r_state)
                IDLE:      if (w_mul_accept) w_next_state = MUL_DRAIN;
                MUL_DRAIN: if (w_mul_push && w_mul_last) w_next_state = IDLE;
                default:   w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        out_ov   = !w_empty;
        out_od   = '0;
        out_last = 1'b0;
        if (!w_empty) {out_last, out_od} = r_mem[r_rptr[AW-1:0]];
        busy     = (r_state != IDLE) || !w_empty;
    end

    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_op_sel   <= 1'b0;
            r_o_width  <= '0;
            r_o_height <= '0;
            r_mul_b_w  <= '0;
            r_mul_b_h  <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_row_idx  <= '0;
            r_pack     <= '0;
            r_mul      <= '0;
            r_overflow <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (load_layer_info) begin
            r_op_sel   <= op_sel;
            r_o_width  <= o_width;
            r_o_height <= o_height;
            r_mul_b_w  <= mul_b_w;
            r_mul_b_h  <= mul_b_h;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_row_idx  <= '0;
            r_pack     <= '0;
            r_overflow <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_conv_accept) begin
                if (w_conv_eol) begin
                    r_pack    <= '0;
                    r_col_cnt <= '0;
                    r_row_cnt <= w_conv_last ? 4'd0 : r_row_cnt + 4'd1;
                end else begin
                    r_pack    <= w_conv_word;
                    r_col_cnt <= r_col_cnt + 4'd1;
                end
            end
            if (w_mul_accept) begin
                r_mul     <= mul_id;
                r_row_idx <= '0;
            end else if (w_mul_push) begin
                r_row_idx <= w_mul_last ? 4'd0 : r_row_idx + 4'd1;
            end
            if (w_drop || w_ignore) r_overflow <= 1'b1;
            if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {w_push_last, w_push_word};
    end

endmodule

// File: tb/tb_ofmap_packer.sv
// Bench for ofmap_packer: table of CONV/MUL layer configurations plus hand-written
// stall, overflow, flush and reset sequences; words checked through a scoreboard.
module tb_ofmap_packer;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int D  = 8;
    localparam int FD = 16;
    localparam int WW = W * D;

    logic            clk = 1'b0;
    logic            nrst, load_layer_info, op_sel;
    logic [3:0]      o_width, o_height, mul_b_w, mul_b_h;
    logic            conv_iv, mul_iv, out_ready;
    logic [D-1:0]    conv_id;
    logic [H*WW-1:0] mul_id;
    logic            out_ov, out_last, busy, overflow;
    logic [WW-1:0]   out_od;

    ofmap_packer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(D), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .nrst(nrst), .load_layer_info(load_layer_info), .op_sel(op_sel),
        .o_width(o_width), .o_height(o_height), .mul_b_w(mul_b_w), .mul_b_h(mul_b_h),
        .conv_iv(conv_iv), .conv_id(conv_id), .mul_iv(mul_iv), .mul_id(mul_id),
        .out_ov(out_ov), .out_od(out_od), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_recv   = 0;
    logic [WW:0] sb_q[$];

    typedef struct {
        bit         op;
        logic [3:0] a;
        logic [3:0] b;
        int         arg;
        int         exp_words;
        bit         exp_busy;
    } vec_t;
    vec_t vecs[7];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [WW:0] act, input logic [WW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // A transfer seen at negedge completes on the following rising edge
    always @(negedge clk) begin
        if (nrst === 1'b1 && out_ov === 1'b1 && out_ready === 1'b1 && load_layer_info === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h required no word", {out_last, out_od});
            end else begin
                check_word("sb_word", {out_last, out_od}, sb_q.pop_front());
            end
            n_recv++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int eff(input logic [3:0] x);
        return (x == 4'd0) ? 8 : int'(x);
    endfunction

    function automatic logic [WW-1:0] conv_word(input int first, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int c = 0; c < W; c++) if (c < n) w[c*D +: D] = 8'(first + c);
        return w;
    endfunction

    function automatic logic [H*WW-1:0] build_mat(input int seed);
        logic [H*WW-1:0] m;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) m[(r*W + c)*D +: D] = 8'(seed + r*8 + c);
        return m;
    endfunction

    function automatic logic [WW-1:0] mul_row(input int seed, input int r, input int bw);
        logic [WW-1:0] w;
        w = '0;
        for (int c = 0; c < W; c++) if (c < bw) w[c*D +: D] = 8'(seed + r*8 + c);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic op, input logic [3:0] a, input logic [3:0] b);
        load_layer_info = 1'b1;
        op_sel = op; o_width = a; o_height = b; mul_b_w = a; mul_b_h = b;
        tick();
        load_layer_info = 1'b0;
    endtask

    task automatic conv_elem(input int val);
        conv_iv = 1'b1;
        conv_id = 8'(val);
        tick();
        conv_iv = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check_int("drain_outstanding", sb_q.size(), 0);
    endtask

    initial begin
        int ow, oh, bw, bh, val;
        vecs[0] = '{1'b0, 4'd6, 4'd2, 2, 2, 1'b1};
        vecs[1] = '{1'b0, 4'd0, 4'd3, 3, 3, 1'b1};
        vecs[2] = '{1'b0, 4'd3, 4'd0, 4, 4, 1'b1};
        vecs[3] = '{1'b1, 4'd8, 4'd8, 0, 8, 1'b0};
        vecs[4] = '{1'b1, 4'd3, 4'd2, 64, 2, 1'b0};
        vecs[5] = '{1'b1, 4'd0, 4'd1, 16, 1, 1'b0};
        vecs[6] = '{1'b0, 4'd1, 4'd1, 3, 3, 1'b1};

        // Reset must dominate a simultaneous load and valid inputs
        nrst = 1'b0; load_layer_info = 1'b1; op_sel = 1'b0;
        o_width = 4'd6; o_height = 4'd2; mul_b_w = 4'd0; mul_b_h = 4'd0;
        conv_iv = 1'b1; conv_id = 8'h55; mul_iv = 1'b1; mul_id = '0; out_ready = 1'b1;
        tick();
        tick();
        check_bit("rst_out_ov", out_ov, 1'b0);
        check_word("rst_out_word", {out_last, out_od}, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_overflow", overflow, 1'b0);
        load_layer_info = 1'b0; conv_iv = 1'b0; mul_iv = 1'b0;
        nrst = 1'b1;
        tick();
        check_bit("rst_dominates_load", busy, 1'b0);

        conv_elem(7);
        check_bit("conv_in_idle_ovf", overflow, 1'b1);
        load(1'b0, 4'd6, 4'd2);
        check_bit("load_clears_ovf", overflow, 1'b0);
        mul_iv = 1'b1; tick(); mul_iv = 1'b0;
        check_bit("mul_in_conv_ovf", overflow, 1'b1);
        check_bit("mul_in_conv_no_word", out_ov, 1'b0);

        for (int i = 0; i < 7; i++) begin
            n_recv = 0;
            out_ready = 1'b1;
            load(vecs[i].op, vecs[i].a, vecs[i].b);
            if (!vecs[i].op) begin
                ow = eff(vecs[i].a);
                oh = eff(vecs[i].b);
                val = 1;
                for (int r = 0; r < vecs[i].arg; r++) begin
                    sb_q.push_back({((r % oh) == oh - 1), conv_word(val, ow)});
                    for (int c = 0; c < ow; c++) begin
                        conv_elem(val + c);
                        check_bit("conv_latency", out_ov, (c == ow - 1));
                    end
                    val += ow;
                end
            end else begin
                bw = eff(vecs[i].a);
                bh = eff(vecs[i].b);
                mul_id = build_mat(vecs[i].arg);
                for (int r = 0; r < bh; r++)
                    sb_q.push_back({(r == bh - 1), mul_row(vecs[i].arg, r, bw)});
                mul_iv = 1'b1; tick(); mul_iv = 1'b0;
                check_bit("mul_lat_t1", out_ov, 1'b0);
                tick();
                check_bit("mul_lat_t2", out_ov, 1'b1);
            end
            wait_drain(64);
            tick();
            check_int("vec_word_count", n_recv, vecs[i].exp_words);
            check_bit("vec_busy_after", busy, vecs[i].exp_busy);
            check_bit("vec_overflow", overflow, 1'b0);
        end

        // Stalled MUL: two narrow rows held at the FIFO head until released
        n_recv = 0;
        load(1'b1, 4'd3, 4'd2);
        out_ready = 1'b0;
        mul_id = build_mat(128);
        for (int r = 0; r < 2; r++) sb_q.push_back({(r == 1), mul_row(128, r, 3)});
        mul_iv = 1'b1; tick(); mul_iv = 1'b0;
        repeat (20) begin
            tick();
            check_word("stall_hold_word", {out_last, out_od}, sb_q[0]);
            check_bit("stall_busy", busy, 1'b1);
        end
        check_bit("stall_no_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        wait_drain(16);
        tick();
        check_int("stall_word_count", n_recv, 2);

        // CONV overflow: 17 one-lane rows into a 16-deep FIFO with no reader
        n_recv = 0;
        load(1'b0, 4'd1, 4'd1);
        out_ready = 1'b0;
        for (int k = 0; k < FD + 1; k++) begin
            if (k < FD) sb_q.push_back({1'b1, conv_word(k + 1, 1)});
            conv_elem(k + 1);
            check_bit("fill_no_ovf_yet", overflow, (k == FD));
        end
        repeat (3) tick();
        check_bit("ovf_sticky", overflow, 1'b1);
        out_ready = 1'b1;
        wait_drain(40);
        tick();
        check_int("ovf_retained_words", n_recv, FD);
        check_bit("ovf_sticky_after_drain", overflow, 1'b1);
        load(1'b0, 4'd6, 4'd2);
        check_bit("ovf_cleared_by_load", overflow, 1'b0);

        // Mid-row reload discards the partial row
        n_recv = 0;
        for (int k = 0; k < 3; k++) conv_elem(8'hA1 + k);
        load(1'b0, 4'd6, 4'd2);
        check_bit("reload_fifo_empty", out_ov, 1'b0);
        check_bit("reload_busy", busy, 1'b1);
        sb_q.push_back({1'b0, conv_word(1, 6)});
        for (int k = 0; k < 6; k++) conv_elem(k + 1);
        wait_drain(16);
        tick();
        check_int("reload_word_count", n_recv, 1);

        // Reset during MUL_DRAIN with rows queued
        load(1'b1, 4'd0, 4'd0);
        out_ready = 1'b0;
        mul_id = build_mat(200);
        mul_iv = 1'b1; tick(); mul_iv = 1'b0;
        repeat (4) tick();
        check_bit("drain_rows_queued", out_ov, 1'b1);
        mul_iv = 1'b1; tick(); mul_iv = 1'b0;
        check_bit("mul_in_drain_ovf", overflow, 1'b1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check_bit("midrst_out_ov", out_ov, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_overflow", overflow, 1'b0);
        check_word("midrst_out_word", {out_last, out_od}, '0);
        sb_q.delete();
        tick();
        check_bit("midrst_stays_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
